// File: rtl/tlc_pkg.sv
// Shared encodings for the intersection phase scheduler.
package tlc_pkg;

  localparam int unsigned N_APP  = 4;
  localparam int unsigned LAMP_W = 3;
  localparam int unsigned OWN_W  = 2;

  localparam logic [LAMP_W-1:0] LIGHT_GREEN  = 3'b100;
  localparam logic [LAMP_W-1:0] LIGHT_YELLOW = 3'b010;
  localparam logic [LAMP_W-1:0] LIGHT_RED    = 3'b001;

  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_ALL_RED = 2'd2
  } phase_e;

endpackage

// File: rtl/rr_next_owner.sv
// Round-robin pick of the next green owner; approach 0 is always eligible.
module rr_next_owner
  import tlc_pkg::*;
(
  input  logic [OWN_W-1:0] owner,
  input  logic [N_APP-1:0] req,
  output logic [OWN_W-1:0] next
);

  logic [OWN_W-1:0] idx;
  logic             found;

  // Scan owner+1 .. owner+4 (wrapping) and take the first eligible approach.
  always_comb begin
    next  = owner;
    found = 1'b0;
    idx   = owner;
    for (int unsigned k = 1; k <= N_APP; k++) begin
      idx = owner + OWN_W'(k);
      if (!found && (req[idx] || (idx == '0))) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Four-approach green-phase scheduler: GREEN -> YELLOW -> ALL_RED, round-robin owner.
module intersection_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 20,
  parameter int unsigned MAX_GREEN = 60,
  parameter int unsigned YELLOW    = 10,
  parameter int unsigned ALL_RED   = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_APP-1:0]          req,
  output logic [N_APP*LAMP_W-1:0]   lights,
  output logic [N_APP-1:0]          grant,
  output logic [1:0]                phase
);

  localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  localparam logic [N_APP*LAMP_W-1:0] LIGHTS_RST = 12'b001_001_001_100;
  localparam logic [N_APP-1:0]        GRANT_RST  = 4'b0001;

  phase_e                    phase_q, phase_d;
  logic [OWN_W-1:0]          owner_q, owner_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N_APP*LAMP_W-1:0]   lights_q, lights_d;
  logic [N_APP-1:0]          grant_q, grant_d;

  logic [OWN_W-1:0]          next_owner;
  logic                      others_wait;
  logic                      exit_green;

  rr_next_owner u_rr (
    .owner (owner_q),
    .req   (req),
    .next  (next_owner)
  );

  // Green may end on the max-green limit (if anyone else waits) or early once a side road empties.
  always_comb begin
    others_wait = (owner_q != '0) || (req[3:1] != 3'b000);
    exit_green  = ((cnt_q == GREEN_MAX_LAST) && others_wait) ||
                  ((owner_q != '0) && !req[owner_q] && (cnt_q >= GREEN_MIN_LAST));
  end

  // Phase sequencing, phase counter and owner hand-over on the last all-red cycle.
  always_comb begin
    phase_d = phase_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (phase_q)
      PH_GREEN: begin
        if (exit_green) begin
          phase_d = PH_YELLOW;
          cnt_d   = '0;
        end else if (cnt_q != GREEN_MAX_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PH_YELLOW: begin
        if (cnt_q == YELLOW_LAST) begin
          phase_d = PH_ALL_RED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PH_ALL_RED: begin
        if (cnt_q == ALL_RED_LAST) begin
          phase_d = PH_GREEN;
          owner_d = next_owner;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        phase_d = PH_GREEN;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamp and grant decode of the upcoming state so the outputs come straight from flops.
  always_comb begin
    lights_d = '0;
    for (int unsigned i = 0; i < N_APP; i++) begin
      lights_d[LAMP_W*i +: LAMP_W] = LIGHT_RED;
      if (owner_d == OWN_W'(i)) begin
        if (phase_d == PH_GREEN)  lights_d[LAMP_W*i +: LAMP_W] = LIGHT_GREEN;
        if (phase_d == PH_YELLOW) lights_d[LAMP_W*i +: LAMP_W] = LIGHT_YELLOW;
      end
    end
    grant_d = (phase_d == PH_ALL_RED) ? '0 : (N_APP'(1) << owner_d);
  end

  // State and output registers with immediate asynchronous return to main-road green.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_GREEN;
      owner_q  <= '0;
      cnt_q    <= '0;
      lights_q <= LIGHTS_RST;
      grant_q  <= GRANT_RST;
    end else begin
      phase_q  <= phase_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
      grant_q  <= grant_d;
    end
  end

  assign lights = lights_q;
  assign grant  = grant_q;
  assign phase  = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with a cycle-level reference model.
module tb_intersection_phase_scheduler;

  localparam int MIN_G = 20;
  localparam int MAX_G = 60;
  localparam int YEL   = 10;
  localparam int ARED  = 2;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] lights;
  logic [3:0]  grant;
  logic [1:0]  phase;

  int n_cmp;
  int n_bad;
  int cyc;
  bit checking;

  // Reference model: owner, phase (0/1/2) and cycles already spent in the phase.
  int m_owner;
  int m_phase;
  int m_age;

  intersection_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW    (YEL),
    .ALL_RED   (ARED),
    .CNT_W     (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .lights (lights),
    .grant  (grant),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since the last reset release (cycle 0 is the reset state).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Behavioural phase schedule.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0;
      m_phase = 0;
      m_age   = 0;
    end else begin
      case (m_phase)
        0: begin
          bit someone_waits;
          bit too_long;
          bit side_empty;
          someone_waits = (m_owner != 0) || (req[3:1] != 3'b000);
          too_long      = (m_age + 1 >= MAX_G) && someone_waits;
          side_empty    = (m_owner != 0) && (req[m_owner] == 1'b0) && (m_age + 1 >= MIN_G);
          if (too_long || side_empty) begin
            m_phase = 1;
            m_age   = 0;
          end else begin
            m_age = m_age + 1;
          end
        end
        1: begin
          if (m_age + 1 == YEL) begin
            m_phase = 2;
            m_age   = 0;
          end else begin
            m_age = m_age + 1;
          end
        end
        default: begin
          if (m_age + 1 == ARED) begin
            int pick;
            pick = m_owner;
            for (int k = 4; k >= 1; k--) begin
              int c;
              c = (m_owner + k) % 4;
              if (c == 0 || req[c]) pick = c;
            end
            m_owner = pick;
            m_phase = 0;
            m_age   = 0;
          end else begin
            m_age = m_age + 1;
          end
        end
      endcase
    end
  end

  function automatic logic [11:0] exp_lights(input int own, input int ph);
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] lamp;
      if (ph == 2 || i != own) lamp = 3'b001;
      else if (ph == 0)        lamp = 3'b100;
      else                     lamp = 3'b010;
      v[3*i +: 3] = lamp;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_grant(input int own, input int ph);
    logic [3:0] g;
    g = '0;
    if (ph != 2) g[own] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d t=%0t: got %b expected %b", name, cyc, $time, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [11:0] el, input logic [3:0] eg,
                         input logic [1:0] ep);
    chk({tag, ".lights"}, lights, el);
    chk({tag, ".grant"}, 12'(grant), 12'(eg));
    chk({tag, ".phase"}, 12'(phase), 12'(ep));
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("model.lights", lights, exp_lights(m_owner, m_phase));
      chk("model.grant", 12'(grant), 12'(exp_grant(m_owner, m_phase)));
      chk("model.phase", 12'(phase), 12'(m_phase));
    end
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    checking = 1'b0;
    req      = 4'b0000;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    checking = 1'b1;

    // Reset state, then idle main road for 1000 cycles.
    chk_all("reset", 12'b001_001_001_100, 4'b0001, 2'd0);
    wait_cyc(1000);
    chk_all("idle1000", 12'b001_001_001_100, 4'b0001, 2'd0);

    // Side road 1 arrives at cycle 5 and holds.
    do_reset();
    wait_cyc(5);
    req = 4'b0010;
    wait_cyc(59);
    chk_all("c59.green0", 12'b001_001_001_100, 4'b0001, 2'd0);
    wait_cyc(60);
    chk_all("c60.yellow0", 12'b001_001_001_010, 4'b0001, 2'd1);
    wait_cyc(69);
    chk_all("c69.yellow0", 12'b001_001_001_010, 4'b0001, 2'd1);
    wait_cyc(70);
    chk_all("c70.allred", 12'b001_001_001_001, 4'b0000, 2'd2);
    wait_cyc(71);
    chk_all("c71.allred", 12'b001_001_001_001, 4'b0000, 2'd2);
    wait_cyc(72);
    chk_all("c72.green1", 12'b001_001_100_001, 4'b0010, 2'd0);

    // Side road 1 empties after 5 cycles: early exit at 20 green cycles.
    wait_cyc(77);
    req = 4'b0000;
    wait_cyc(91);
    chk_all("c91.green1", 12'b001_001_100_001, 4'b0010, 2'd0);
    wait_cyc(92);
    chk_all("c92.yellow1", 12'b001_001_010_001, 4'b0010, 2'd1);
    wait_cyc(104);
    chk_all("c104.green0", 12'b001_001_001_100, 4'b0001, 2'd0);

    // All side roads busy: full-length rotation 0 -> 1 -> 2 -> 3 -> 0.
    wait_cyc(110);
    req = 4'b1110;
    wait_cyc(163);
    chk_all("c163.green0", 12'b001_001_001_100, 4'b0001, 2'd0);
    wait_cyc(176);
    chk_all("c176.green1", 12'b001_001_100_001, 4'b0010, 2'd0);
    wait_cyc(248);
    chk_all("c248.green2", 12'b001_100_001_001, 4'b0100, 2'd0);
    wait_cyc(320);
    chk_all("c320.green3", 12'b100_001_001_001, 4'b1000, 2'd0);
    wait_cyc(392);
    chk_all("c392.green0", 12'b001_001_001_100, 4'b0001, 2'd0);
    wait_cyc(536);
    chk_all("c536.green2", 12'b001_100_001_001, 4'b0100, 2'd0);

    // Owner 2 with req=1010; road 3 leaves during yellow so the scan lands on 0.
    wait_cyc(538);
    req = 4'b1010;
    wait_cyc(556);
    chk_all("c556.yellow2", 12'b001_010_001_001, 4'b0100, 2'd1);
    wait_cyc(558);
    req = 4'b0010;
    wait_cyc(567);
    chk_all("c567.allred", 12'b001_001_001_001, 4'b0000, 2'd2);
    wait_cyc(568);
    chk_all("c568.green0", 12'b001_001_001_100, 4'b0001, 2'd0);

    // Asynchronous reset in the middle of approach 1 yellow.
    wait_cyc(704);
    chk_all("c704.yellow1", 12'b001_001_010_001, 4'b0010, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 12'b001_001_001_100, 4'b0001, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(60);
    chk_all("post.c60.yellow0", 12'b001_001_001_010, 4'b0001, 2'd1);
    wait_cyc(72);
    chk_all("post.c72.green1", 12'b001_001_100_001, 4'b0010, 2'd0);
    wait_cyc(80);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
